axis_fifo_pkt: RTL

Parametrised AXI4-Stream FIFO with full ready/valid handshake on both sides. Generalises data width, depth and sideband (tuser).
Adds almost-full/almost-empty flags, a fill level output and an optional store-and-forward packet mode.
Sits between AXIS producers and consumers in stream datapaths. Storage maps to block RAM.

---
 rtl/axis_fifo_pkg.sv | 16 +
 rtl/sdp_ram.sv | 32 +++
 rtl/axis_fifo_pkt.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/axis_fifo_pkg.sv
// Shared sizing helpers and default thresholds for the AXI4-Stream packet FIFO.
package axis_fifo_pkg;

    localparam int AEMPTY_TH_DEF    = 4;
    localparam int AFULL_MARGIN_DEF = 4;

    function automatic int fifo_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

    // Each stored word is {tlast, tuser, tdata}.
    function automatic int ram_word_w(input int data_w, input int user_w);
        return data_w + user_w + 1;
    endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset on contents.
module sdp_ram
    import axis_fifo_pkg::*;
#(
    parameter int WIDTH  = 10,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    (* ram_style = "block" *) logic [WIDTH-1:0] mem [fifo_depth(ADDR_W)];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The read register doubles as the FIFO output register; it holds while rd_en is low.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/axis_fifo_pkt.sv
// AXI4-Stream FIFO with fill level, almost flags and optional store-and-forward gating.
module axis_fifo_pkt
    import axis_fifo_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int USER_W      = 1,
    parameter int ADDR_W      = 11,
    parameter int PACKET_MODE = 0,
    parameter int AFULL_TH    = fifo_depth(ADDR_W) - AFULL_MARGIN_DEF,
    parameter int AEMPTY_TH   = AEMPTY_TH_DEF
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic [USER_W-1:0] s_axis_tuser,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [USER_W-1:0] m_axis_tuser,
    output logic              m_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [ADDR_W:0]   level,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              oversize_err
);

    localparam int WORD_W = ram_word_w(DATA_W, USER_W);
    localparam int PTR_W  = ADDR_W + 1;

    logic [PTR_W-1:0]  wr_ptr, wr_ptr_d, rd_ptr;
    logic [PTR_W-1:0]  wr_ptr_nxt, rd_ptr_nxt;
    logic [PTR_W-1:0]  level_q, level_nxt;
    logic [WORD_W-1:0] rd_word;
    logic              tready_q, out_valid;
    logic              s_hs, m_hs, prefetch, gate_open;
    logic              ram_empty_vis, full_nxt;

    assign s_hs = s_axis_tvalid & tready_q;
    assign m_hs = out_valid & m_axis_tready;

    // Reads compare against the write pointer delayed by one edge, so a word
    // becomes readable the cycle after it is written.
    assign ram_empty_vis = (wr_ptr_d == rd_ptr);
    assign prefetch      = !ram_empty_vis && (!out_valid || m_axis_tready) && gate_open;

    assign wr_ptr_nxt = wr_ptr + PTR_W'(s_hs);
    assign rd_ptr_nxt = rd_ptr + PTR_W'(prefetch);
    assign full_nxt   = (wr_ptr_nxt[ADDR_W] != rd_ptr_nxt[ADDR_W]) &&
                        (wr_ptr_nxt[ADDR_W-1:0] == rd_ptr_nxt[ADDR_W-1:0]);
    assign level_nxt  = level_q + PTR_W'(s_hs) - PTR_W'(m_hs);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr       <= '0;
            wr_ptr_d     <= '0;
            rd_ptr       <= '0;
            tready_q     <= 1'b0;
            out_valid    <= 1'b0;
            level_q      <= '0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            wr_ptr       <= wr_ptr_nxt;
            wr_ptr_d     <= wr_ptr;
            rd_ptr       <= rd_ptr_nxt;
            tready_q     <= !full_nxt;
            level_q      <= level_nxt;
            almost_full  <= int'(level_nxt) >= AFULL_TH;
            almost_empty <= int'(level_nxt) <= AEMPTY_TH;
            if (prefetch) begin
                out_valid <= 1'b1;
            end else if (m_axis_tready) begin
                out_valid <= 1'b0;
            end
        end
    end

    sdp_ram #(
        .WIDTH  (WORD_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (aclk),
        .wr_en   (s_hs),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_data ({s_axis_tlast, s_axis_tuser, s_axis_tdata}),
        .rd_en   (prefetch),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_data (rd_word)
    );

    generate
        if (PACKET_MODE != 0) begin : g_pkt
            logic [PTR_W-1:0] pkt_cnt;
            logic [PTR_W-1:0] pkt_pending;
            logic             last_wr_d;
            logic             release_q;
            logic             err_q;
            logic             m_last_hs;
            logic             ram_full;

            assign m_last_hs = m_hs & m_axis_tlast;
            assign ram_full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                               (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

            // A packet whose tlast landed on the last edge is not readable yet, and
            // one whose tlast leaves this cycle must not let the next packet through.
            assign pkt_pending = PTR_W'(last_wr_d) + PTR_W'(m_last_hs);
            assign gate_open   = (pkt_cnt > pkt_pending) || (release_q && !m_last_hs);

            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    pkt_cnt   <= '0;
                    last_wr_d <= 1'b0;
                    release_q <= 1'b0;
                    err_q     <= 1'b0;
                end else begin
                    pkt_cnt   <= pkt_cnt + PTR_W'(s_hs & s_axis_tlast) - PTR_W'(m_last_hs);
                    last_wr_d <= s_hs & s_axis_tlast;
                    if (ram_full && (pkt_cnt == '0)) begin
                        release_q <= 1'b1;
                        err_q     <= 1'b1;
                    end else if (m_last_hs) begin
                        release_q <= 1'b0;
                    end
                end
            end

            assign oversize_err = err_q;
        end else begin : g_ct
            assign gate_open    = 1'b1;
            assign oversize_err = 1'b0;
        end
    endgenerate

    assign s_axis_tready = tready_q;
    assign m_axis_tvalid = out_valid;
    assign {m_axis_tlast, m_axis_tuser, m_axis_tdata} = rd_word;
    assign level = level_q;

endmodule
